// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath constants, word type and select-width helper
package cpu_pkg;
    localparam int DATA_W = 32;
    typedef logic [DATA_W-1:0] word_t;
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mux_n_comb.sv
// mux_n_comb: combinational N-to-1 selector with in-range flag
//   data_i   N packed SIZE-bit channels, channel k = data_i[k*SIZE +: SIZE]
//   select_i channel index
//   sel      selected channel, zero when select_i >= N
//   in_range high when select_i < N
module mux_n_comb
    import cpu_pkg::*;
#(
    parameter int SIZE  = DATA_W,
    parameter int N     = 3,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N*SIZE-1:0] data_i,
    input  logic [SEL_W-1:0]  select_i,
    output logic [SIZE-1:0]   sel,
    output logic              in_range
);
    always_comb begin
        sel      = '0;
        in_range = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (select_i == SEL_W'(k)) begin
                sel      = data_i[k*SIZE +: SIZE];
                in_range = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sel_pipe_reg.sv
// sel_pipe_reg: N-way forwarding mux with registered output, valid, stall, flush and select-error flag
//   clk_i, rst_i (async, active-low)
//   data_i/select_i/valid_i  input beat; stall_i holds, flush_i inserts a bubble (flush wins)
//   data_o/valid_o/sel_err_o registered outputs, one cycle latency
//   SEL_PIPE_STATS_EN adds stall_cnt_o: saturating count of stalled (non-flushed) edges
module sel_pipe_reg
    import cpu_pkg::*;
#(
    parameter int              SIZE    = DATA_W,
    parameter int              N       = 3,
    parameter int              SEL_W   = sel_width(N),
    parameter logic [SIZE-1:0] DEFAULT = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N*SIZE-1:0] data_i,
    input  logic [SEL_W-1:0]  select_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
`ifdef SEL_PIPE_STATS_EN
    output logic [15:0]       stall_cnt_o,
`endif
    output logic [SIZE-1:0]   data_o,
    output logic              valid_o,
    output logic              sel_err_o
);
    logic [SIZE-1:0] sel;
    logic            in_range;

    mux_n_comb #(.SIZE(SIZE), .N(N), .SEL_W(SEL_W)) u_mux (
        .data_i   (data_i),
        .select_i (select_i),
        .sel      (sel),
        .in_range (in_range)
    );

    // capture ignores valid_i; consumers qualify data_o with valid_o
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o    <= DEFAULT;
            valid_o   <= 1'b0;
            sel_err_o <= 1'b0;
        end else if (flush_i) begin
            data_o    <= DEFAULT;
            valid_o   <= 1'b0;
            sel_err_o <= 1'b0;
        end else if (!stall_i) begin
            data_o    <= in_range ? sel : DEFAULT;
            valid_o   <= valid_i;
            sel_err_o <= !in_range;
        end
    end

`ifdef SEL_PIPE_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_cnt_o <= '0;
        else if (stall_i && !flush_i && stall_cnt_o != 16'hFFFF)
            stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_sel_pipe_reg.sv
// tb_sel_pipe_reg: scoreboard bench for sel_pipe_reg against a behavioural model
module tb_sel_pipe_reg;
    localparam int SIZE = 32;
    localparam int N    = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N*SIZE-1:0] data_i;
    logic [1:0]      select_i;
    logic            valid_i, stall_i, flush_i;
    logic [SIZE-1:0] data_o;
    logic            valid_o, sel_err_o;
`ifdef SEL_PIPE_STATS_EN
    logic [15:0]     stall_cnt_o;
    logic [15:0]     mc = '0;
`endif

    sel_pipe_reg #(.SIZE(SIZE), .N(N), .SEL_W(2), .DEFAULT('0)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .select_i  (select_i),
        .valid_i   (valid_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
`ifdef SEL_PIPE_STATS_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .data_o    (data_o),
        .valid_o   (valid_o),
        .sel_err_o (sel_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [SIZE-1:0] d;
        logic            v;
        logic            e;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic [SIZE-1:0] md = '0;
    logic            mv = 1'b0;
    logic            me = 1'b0;

    task automatic check(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every edge with a pending expectation is compared off the edge
    always @(posedge clk_i) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("data_o", data_o, e.d);
            check("valid_o", SIZE'(valid_o), SIZE'(e.v));
            check("sel_err_o", SIZE'(sel_err_o), SIZE'(e.e));
        end
    end

    // model: flush beats stall, stall holds, otherwise select channel or flag out-of-range
    task automatic drive(input logic [N*SIZE-1:0] d, input logic [1:0] s,
                         input logic v, input logic st, input logic fl);
        data_i = d; select_i = s; valid_i = v; stall_i = st; flush_i = fl;
        if (fl) begin
            md = '0; mv = 1'b0; me = 1'b0;
        end else if (!st) begin
            mv = v;
            me = (int'(s) >= N);
            md = me ? '0 : SIZE'(d >> (int'(s) * SIZE));
        end
`ifdef SEL_PIPE_STATS_EN
        if (st && !fl && mc != 16'hFFFF) mc = mc + 16'd1;
`endif
        q.push_back('{md, mv, me});
        @(negedge clk_i);
    endtask

    task automatic async_reset();
        stall_i = 1'b1;
        flush_i = 1'b0;
        rst_i = 1'b0;
        #1;
        check("rst_data_o", data_o, '0);
        check("rst_valid_o", SIZE'(valid_o), '0);
        check("rst_sel_err_o", SIZE'(sel_err_o), '0);
`ifdef SEL_PIPE_STATS_EN
        check("rst_stall_cnt_o", SIZE'(stall_cnt_o), '0);
        mc = '0;
`endif
        md = '0; mv = 1'b0; me = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        stall_i = 1'b0;
    endtask

    localparam logic [N*SIZE-1:0] ABC = {32'd3, 32'd2, 32'd1};

    initial begin
        rst_i = 1'b0;
        data_i = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
        select_i = 2'd1; valid_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        #1;
        check("init_data_o", data_o, '0);
        check("init_valid_o", SIZE'(valid_o), '0);
        check("init_sel_err_o", SIZE'(sel_err_o), '0);
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(ABC, 2'd1, 1'b1, 1'b0, 1'b0);
        drive(ABC, 2'd3, 1'b1, 1'b0, 1'b0);
        drive(ABC, 2'd0, 1'b1, 1'b0, 1'b0);
        drive(ABC, 2'd1, 1'b0, 1'b0, 1'b0);
        drive(ABC, 2'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive({$urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b0);
        drive(ABC, 2'd2, 1'b1, 1'b1, 1'b1);
        drive(ABC, 2'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            drive({$urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end
`ifdef SEL_PIPE_STATS_EN
        async_reset();
        for (int i = 0; i < 5; i++) drive(ABC, 2'd0, 1'b1, 1'b1, 1'b0);
        drive(ABC, 2'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) drive(ABC, 2'd0, 1'b1, 1'b1, 1'b0);
        check("stall_cnt_7", SIZE'(stall_cnt_o), SIZE'(16'd7));
        force dut.stall_cnt_o = 16'hFFFE;
        #1;
        release dut.stall_cnt_o;
        mc = 16'hFFFE;
        for (int i = 0; i < 3; i++) drive(ABC, 2'd0, 1'b1, 1'b1, 1'b0);
        check("stall_cnt_sat", SIZE'(stall_cnt_o), SIZE'(16'hFFFF));
        check("stall_cnt_model", SIZE'(stall_cnt_o), SIZE'(mc));
`endif
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk_i);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
